song_note_feeder: RTL and testbench

Chart-side responder for the per-note matching array: owns a read port into the song-chart ROM and keeps, for each of the 37 notes, the time of that note's next unmatched chart entry on `metadata_link`. When a note's matcher pulses `metadata_request` (its current entry was consumed or missed), the feeder advances that note's pointer and fetches the next time. It sits between the chart ROM and the note-matching array, driven by the same system clock.

---
 rtl/song_note_feeder_if.sv | 24 ++
 rtl/song_note_feeder.sv | 161 ++++++++++++++++
 tb/tb_song_note_feeder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/song_note_feeder_if.sv
// Port bundle for song_note_feeder: note-matcher side (load, requests, links, ready)
// and the chart ROM read port (mem_addr out, mem_data back).
interface song_note_feeder_if #(
    parameter int NOTES  = 37,
    parameter int TIME_W = 18,
    parameter int ADDR_W = 12
);
    logic                    load;
    logic [NOTES-1:0]        metadata_request;
    logic [NOTES*TIME_W-1:0] metadata_link;
    logic                    ready;
    logic [ADDR_W-1:0]       mem_addr;
    logic [TIME_W-1:0]       mem_data;

    // slave is the feeder; master is the matcher array together with the chart ROM
    modport slave (
        input  load, metadata_request, mem_data,
        output metadata_link, ready, mem_addr
    );
    modport master (
        output load, metadata_request, mem_data,
        input  metadata_link, ready, mem_addr
    );
endinterface

// File: rtl/song_note_feeder.sv
// Keeps each note lane's next unmatched chart time, refetching from the chart ROM on request.
// Define FEEDER_RR_ARB_EN for round-robin lane arbitration; default is lowest-index priority.
module song_note_feeder #(
    parameter int NOTES  = 37,
    parameter int TIME_W = 18,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    song_note_feeder_if.slave bus
);
    localparam int                IDX_W = $clog2(NOTES);
    localparam logic [TIME_W-1:0] END_T = '1;

    typedef enum logic [2:0] {IDLE, H_ADDR, H_CAP, T_CAP, ARB, FETCH} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, sel, grant;
    logic [ADDR_W-1:0] ptr [NOTES];
    logic [TIME_W-1:0] link [NOTES];
    logic [NOTES-1:0]  pending, req_q, accept, clr, fetching;
    logic [ADDR_W-1:0] mem_addr, addr_nx, head;
    logic              ready, grant_any;

    assign head = bus.mem_data[ADDR_W-1:0];

`ifdef FEEDER_RR_ARB_EN
    logic [IDX_W-1:0] last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= IDX_W'(NOTES-1);
        else if (state == ARB && grant_any && !bus.load)
            last <= grant;
    end

    // Walk downward so the lane nearest after `last` is the final, winning assignment.
    always_comb begin
        grant_any = 1'b0;
        grant     = '0;
        for (int k = NOTES; k >= 1; k--) begin
            if (pending[(int'(last) + k) % NOTES]) begin
                grant_any = 1'b1;
                grant     = IDX_W'((int'(last) + k) % NOTES);
            end
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant     = '0;
        for (int k = NOTES-1; k >= 0; k--) begin
            if (pending[k]) begin
                grant_any = 1'b1;
                grant     = IDX_W'(k);
            end
        end
    end
`endif

    // A request counts unless the lane is exhausted (END shown and nothing in flight for it).
    always_comb begin
        accept = '0;
        for (int i = 0; i < NOTES; i++) begin
            fetching[i] = (state == FETCH) && (sel == IDX_W'(i));
            clr[i]      = (state == ARB) && grant_any && (grant == IDX_W'(i));
            if (state == ARB || state == FETCH)
                accept[i] = bus.metadata_request[i] &&
                            ((link[i] != END_T) || pending[i] || req_q[i] || fetching[i]);
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        addr_nx  = mem_addr;
        case (state)
            IDLE:   ;
            H_ADDR: begin
                addr_nx  = ADDR_W'(idx);
                state_nx = H_CAP;
            end
            H_CAP:  begin
                addr_nx  = head;
                state_nx = T_CAP;
            end
            T_CAP:  state_nx = (idx == IDX_W'(NOTES-1)) ? ARB : H_ADDR;
            ARB:    if (grant_any) begin
                addr_nx  = ptr[grant] + ADDR_W'(1);
                state_nx = FETCH;
            end
            FETCH:  state_nx = ARB;
            default: state_nx = IDLE;
        endcase
        if (bus.load)
            state_nx = H_ADDR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // NOTE: ptr/link are flop arrays read every cycle, not a RAM, so they take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            sel      <= '0;
            mem_addr <= '0;
            ready    <= 1'b0;
            pending  <= '0;
            req_q    <= '0;
            for (int i = 0; i < NOTES; i++) begin
                ptr[i]  <= '0;
                link[i] <= END_T;
            end
        end else begin
            mem_addr <= addr_nx;
            if (bus.load) begin
                idx     <= '0;
                ready   <= 1'b0;
                pending <= '0;
                req_q   <= '0;
                for (int i = 0; i < NOTES; i++)
                    link[i] <= END_T;
            end else begin
                // Accepted requests sit one cycle in req_q; a fresh set beats a same-edge clear.
                req_q   <= accept;
                pending <= (pending & ~clr) | req_q;
                case (state)
                    H_CAP: ptr[idx] <= head;
                    T_CAP: begin
                        link[idx] <= bus.mem_data;
                        if (idx == IDX_W'(NOTES-1))
                            ready <= 1'b1;
                        else
                            idx <= idx + IDX_W'(1);
                    end
                    ARB: if (grant_any) begin
                        ptr[grant] <= ptr[grant] + ADDR_W'(1);
                        sel        <= grant;
                    end
                    FETCH: link[sel] <= bus.mem_data;
                    default: ;
                endcase
                for (int i = 0; i < NOTES; i++)
                    if (accept[i])
                        link[i] <= END_T;
            end
        end
    end

    assign bus.mem_addr = mem_addr;
    assign bus.ready    = ready;

    for (genvar g = 0; g < NOTES; g++) begin : g_pack
        assign bus.metadata_link[TIME_W*g +: TIME_W] = link[g];
    end
endmodule

// File: tb/tb_song_note_feeder.sv
// Bench for song_note_feeder: directed chart walk-through plus randomized charts and request
// bursts checked against a per-lane "entries consumed" model.
module tb_song_note_feeder;
    localparam int                NOTES  = 37;
    localparam int                TIME_W = 18;
    localparam int                ADDR_W = 12;
    localparam logic [TIME_W-1:0] END_T  = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    song_note_feeder_if #(.NOTES(NOTES), .TIME_W(TIME_W), .ADDR_W(ADDR_W)) bus ();
    song_note_feeder #(.NOTES(NOTES), .TIME_W(TIME_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Chart ROM: data follows the registered address, sampled by the DUT on the next edge.
    logic [TIME_W-1:0] rom [4096];
    assign bus.mem_data = rom[bus.mem_addr];

    int checks   = 0;
    int failures = 0;
    logic [TIME_W-1:0] exp_links [NOTES];

    // Random-phase model: each lane's chart entries and how many have been consumed.
    int                lane_len [NOTES];
    int                pos      [NOTES];
    logic [TIME_W-1:0] lane_t   [NOTES][4];

    typedef struct {
        int                req_a;
        int                req_b;
        int                lane;
        logic [TIME_W-1:0] exp;
        int                exp_addr;
    } step_t;
    step_t steps [29];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TIME_W-1:0] get_link(input int i);
        return bus.metadata_link[TIME_W*i +: TIME_W];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_links(input string name);
        int bad = -1;
        checks++;
        for (int i = NOTES-1; i >= 0; i--)
            if (get_link(i) !== exp_links[i]) bad = i;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: lane %0d link=%0h expected %0h", name, bad, get_link(bad), exp_links[bad]);
        end
    endtask

    task automatic all_end();
        for (int i = 0; i < NOTES; i++) exp_links[i] = END_T;
    endtask

    task automatic do_load(input string name);
        int n = 0;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check({name, " ready after load"}, bus.ready, 0);
        all_end();
        check_links({name, " links after load"});
        while (!bus.ready && n < 300) begin
            tick();
            n++;
        end
        check({name, " init cycles"}, n, 111);
    endtask

    task automatic directed_rom();
        for (int a = 0; a < 4096; a++) rom[a] = END_T;
        for (int i = 0; i < NOTES; i++) rom[i] = TIME_W'(60);
        rom[0] = 40;  rom[2] = 50;  rom[3] = 62;  rom[5] = 53;  rom[7] = 56;  rom[9] = 64;
        rom[40] = 100; rom[41] = 200;
        rom[50] = 300; rom[51] = 310;
        rom[53] = 500; rom[54] = 510;
        rom[56] = 700; rom[57] = 710; rom[58] = 720;
        rom[62] = 400;
        rom[64] = 900;
    endtask

    task automatic directed_heads();
        all_end();
        exp_links[0] = 100; exp_links[2] = 300; exp_links[3] = 400;
        exp_links[5] = 500; exp_links[7] = 700; exp_links[9] = 900;
    endtask

    task automatic random_rom();
        int addr = 100;
        int t;
        for (int a = 0; a < 4096; a++) rom[a] = END_T;
        for (int i = 0; i < NOTES; i++) begin
            rom[i]      = TIME_W'(addr);
            lane_len[i] = int'($urandom_range(0, 4));
            pos[i]      = 0;
            t           = int'($urandom_range(1, 1000));
            for (int k = 0; k < lane_len[i]; k++) begin
                lane_t[i][k]  = TIME_W'(t);
                rom[addr + k] = TIME_W'(t);
                t += int'($urandom_range(1, 5000));
            end
            addr += lane_len[i] + 1;
        end
    endtask

    function automatic logic [TIME_W-1:0] model_time(input int i);
        return (pos[i] < lane_len[i]) ? lane_t[i][pos[i]] : END_T;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NOTES-1:0] mask;

        steps[0]  = '{0, -1, 0, END_T, -1};
        steps[1]  = '{-1, -1, 0, END_T, -1};
        steps[2]  = '{-1, -1, 0, END_T, -1};
        steps[3]  = '{-1, -1, 0, 18'd200, 41};
        steps[4]  = '{0, -1, 0, END_T, -1};
        steps[5]  = '{-1, -1, 0, END_T, -1};
        steps[6]  = '{-1, -1, 0, END_T, -1};
        steps[7]  = '{-1, -1, 0, END_T, 42};
        steps[8]  = '{0, -1, 0, END_T, -1};
        steps[9]  = '{-1, -1, 0, END_T, -1};
        steps[10] = '{-1, -1, 0, END_T, -1};
        steps[11] = '{-1, -1, 0, END_T, 42};
        steps[12] = '{3, -1, 3, END_T, -1};
        steps[13] = '{-1, -1, 3, END_T, -1};
        steps[14] = '{-1, -1, 3, END_T, -1};
        steps[15] = '{-1, -1, 3, END_T, 63};
        steps[16] = '{5, 2, 2, END_T, -1};
        steps[17] = '{-1, -1, 5, END_T, -1};
        steps[18] = '{-1, -1, 2, END_T, -1};
`ifdef FEEDER_RR_ARB_EN
        steps[19] = '{-1, -1, 5, 18'd510, -1};
        steps[20] = '{-1, -1, 2, END_T, -1};
        steps[21] = '{-1, -1, 2, 18'd310, 51};
`else
        steps[19] = '{-1, -1, 2, 18'd310, -1};
        steps[20] = '{-1, -1, 5, END_T, -1};
        steps[21] = '{-1, -1, 5, 18'd510, 54};
`endif
        steps[22] = '{7, -1, 7, END_T, -1};
        steps[23] = '{-1, -1, 7, END_T, -1};
        steps[24] = '{-1, -1, 7, END_T, 57};
        steps[25] = '{7, -1, 7, END_T, -1};
        steps[26] = '{-1, -1, 7, END_T, -1};
        steps[27] = '{-1, -1, 7, END_T, 58};
        steps[28] = '{-1, -1, 7, 18'd720, -1};

        bus.load = 1'b0;
        bus.metadata_request = '0;
        directed_rom();

        #2 rst_n = 1'b0;
        #1;
        all_end();
        check_links("reset links");
        check("reset mem_addr", bus.mem_addr, 0);
        check("reset ready", bus.ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_load("directed");
        directed_heads();
        check_links("directed heads");

        for (int s = 0; s < 29; s++) begin
            bus.metadata_request = '0;
            if (steps[s].req_a >= 0) bus.metadata_request[steps[s].req_a] = 1'b1;
            if (steps[s].req_b >= 0) bus.metadata_request[steps[s].req_b] = 1'b1;
            tick();
            bus.metadata_request = '0;
            check($sformatf("step %0d lane %0d link", s, steps[s].lane),
                  get_link(steps[s].lane), steps[s].exp);
            if (steps[s].exp_addr >= 0)
                check($sformatf("step %0d mem_addr", s), bus.mem_addr, steps[s].exp_addr);
        end

        // Reload while lanes 2, 5, 7 and 9 are pending.
        bus.metadata_request = '0;
        bus.metadata_request[2] = 1'b1;
        bus.metadata_request[5] = 1'b1;
        bus.metadata_request[7] = 1'b1;
        bus.metadata_request[9] = 1'b1;
        tick();
        bus.metadata_request = '0;
        tick();
        do_load("reload");
        directed_heads();
        check_links("reload heads");
        repeat (12) tick();
        check_links("reload no stale pending");

        // Reset in the middle of lane 20's head fetch.
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (61) tick();
        check("mid-init mem_addr", bus.mem_addr, 20);
        check("mid-init lane0", get_link(0), 100);
        #1 rst_n = 1'b0;
        #1;
        all_end();
        check_links("mid-init reset links");
        check("mid-init reset mem_addr", bus.mem_addr, 0);
        check("mid-init reset ready", bus.ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) tick();
        check("after reset no ready", bus.ready, 0);
        check("after reset mem_addr", bus.mem_addr, 0);
        check_links("after reset links");

        // Random charts and request bursts.
        random_rom();
        do_load("random");
        for (int i = 0; i < NOTES; i++) exp_links[i] = model_time(i);
        check_links("random heads");
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < NOTES; i++) mask[i] = ($urandom_range(0, 2) == 0);
            bus.metadata_request = mask;
            tick();
            bus.metadata_request = '0;
            for (int i = 0; i < NOTES; i++) exp_links[i] = mask[i] ? END_T : model_time(i);
            check_links($sformatf("burst %0d request edge", b));
            for (int i = 0; i < NOTES; i++)
                if (mask[i] && pos[i] < lane_len[i]) pos[i]++;
            repeat (2*NOTES + 4) tick();
            for (int i = 0; i < NOTES; i++) exp_links[i] = model_time(i);
            check_links($sformatf("burst %0d settled", b));
        end
        check("random ready held", bus.ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
